// File: rtl/lbp_pkg.sv
// Shared sizing and state encoding for the LBP host-side image/result memory.
package lbp_pkg;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;
  localparam int IMG_DIM = 2 ** (ADDR_W / 2);
  localparam int N_PIX   = IMG_DIM * IMG_DIM;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2,
    ST_DONE  = 2'd3
  } lbp_state_e;
endpackage

// File: rtl/lbp_pix_ram.sv
// Pixel array: one synchronous write port, one asynchronous read port, no reset on contents.
module lbp_pix_ram #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/lbp_host_mem.sv
// Host-side image memory for the LBP engine: clear results, stream image in, serve the
// engine, then expose results for readback.
//   state | meaning
//   CLEAR | zero one result word per cycle, all N_PIX addresses
//   LOAD  | accept raster-order image beats into the image RAM
//   SERVE | engine reads pixels, writes LBP codes; finish ends the run
//   DONE  | results readable via rd_addr/rd_data; left only by reset
module lbp_host_mem
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic [ADDR_W-1:0] wr_cnt
);
  lbp_state_e        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] load_ptr;

  logic              img_we;
  logic [DATA_W-1:0] img_rdata;
  logic              res_we;
  logic [ADDR_W-1:0] res_waddr;
  logic [DATA_W-1:0] res_wdata;
  logic [DATA_W-1:0] res_rdata;

  logic load_beat;
  logic in_clear;
  logic in_serve;

  assign in_clear  = (state == ST_CLEAR);
  assign in_serve  = (state == ST_SERVE);
  assign load_beat = (state == ST_LOAD) && load_valid && load_ready;

  assign img_we    = load_beat;
  assign res_we    = in_clear || (in_serve && lbp_valid);
  assign res_waddr = in_clear ? clr_ptr : lbp_addr;
  assign res_wdata = in_clear ? '0 : lbp_data;

  // Zero-latency read so the engine sees data the cycle after it registers gray_addr.
  assign gray_data = (in_serve && gray_req) ? img_rdata : '0;

  lbp_pix_ram #(.AW(ADDR_W), .DW(DATA_W)) u_img_ram (
    .clk   (clk),
    .we    (img_we),
    .waddr (load_ptr),
    .wdata (load_data),
    .raddr (gray_addr),
    .rdata (img_rdata)
  );

  lbp_pix_ram #(.AW(ADDR_W), .DW(DATA_W)) u_res_ram (
    .clk   (clk),
    .we    (res_we),
    .waddr (res_waddr),
    .wdata (res_wdata),
    .raddr (rd_addr),
    .rdata (res_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_CLEAR;
      clr_ptr    <= '0;
      load_ptr   <= '0;
      wr_cnt     <= '0;
      gray_ready <= 1'b0;
      load_ready <= 1'b0;
      done       <= 1'b0;
      rd_data    <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) begin
            state      <= ST_LOAD;
            load_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_beat) begin
            load_ptr <= load_ptr + 1'b1;
            if (load_ptr == LAST_ADDR) begin
              state      <= ST_SERVE;
              load_ready <= 1'b0;
              gray_ready <= 1'b1;
            end
          end
        end
        ST_SERVE: begin
          // A write in the finishing cycle still lands; the count saturates at all-ones.
          if (lbp_valid && (wr_cnt != '1)) wr_cnt <= wr_cnt + 1'b1;
          if (finish) begin
            state      <= ST_DONE;
            gray_ready <= 1'b0;
            done       <= 1'b1;
          end
        end
        ST_DONE: begin
          rd_data <= res_rdata;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem: clear timing, image load, serve reads/writes, finish, abort.
module tb_lbp_host_mem;
  import lbp_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_ready;
  logic              gray_ready;
  logic              gray_req = 1'b0;
  logic [ADDR_W-1:0] gray_addr = '0;
  logic [DATA_W-1:0] gray_data;
  logic              lbp_valid = 1'b0;
  logic [ADDR_W-1:0] lbp_addr = '0;
  logic [DATA_W-1:0] lbp_data = '0;
  logic              finish = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic [ADDR_W-1:0] wr_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lbp_host_mem dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .done       (done),
    .wr_cnt     (wr_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input string tag);
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_cmp++;
    if ({load_ready, gray_ready, done} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_flags: got lr/gr/done=%b required 000", tag, {load_ready, gray_ready, done});
    end
    n_cmp++;
    if (wr_cnt !== '0) begin
      n_err++;
      $display("FAIL %s_wr_cnt: got %0d required 0", tag, wr_cnt);
    end
    n_cmp++;
    if (rd_data !== '0) begin
      n_err++;
      $display("FAIL %s_rd_data: got %h required 00", tag, rd_data);
    end
  endtask

  // load_ready must rise exactly on the N_PIX-th edge after reset; gray_ready stays low.
  task automatic test_clear(input string tag);
    int bad = 0;
    for (int i = 1; i <= N_PIX; i++) begin
      step();
      if ((i < N_PIX) && (load_ready !== 1'b0)) bad++;
      if (gray_ready !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s_early_ready: got %0d bad cycles required 0", tag, bad);
    end
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_load_ready_rise: got %b required 1 at cycle %0d", tag, load_ready, N_PIX + 1);
    end
  endtask

  // Streams n_beats of pattern a[7:0]^inv; gaps also poke engine inputs that must be ignored.
  task automatic test_load(input string tag, input int n_beats, input logic [7:0] inv,
                           input bit gaps);
    int bad = 0;
    int n_gaps = 0;
    logic [ADDR_W-1:0] av;
    for (int a = 0; a < n_beats; a++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) begin
        load_valid = 1'b0;
        lbp_valid  = 1'b1;
        lbp_addr   = 14'h0100;
        lbp_data   = 8'hFF;
        finish     = 1'b1;
        gray_req   = 1'b1;
        gray_addr  = 14'h0081;
        #1;
        if (gray_data !== '0) bad++;
        step();
        n_gaps++;
        lbp_valid = 1'b0;
        finish    = 1'b0;
        gray_req  = 1'b0;
      end
      av = ADDR_W'(a);
      load_valid = 1'b1;
      load_data  = av[7:0] ^ inv;
      if (a == N_PIX - 1) begin
        n_cmp++;
        if ({load_ready, gray_ready} !== 2'b10) begin
          n_err++;
          $display("FAIL %s_before_last: got lr/gr=%b required 10", tag, {load_ready, gray_ready});
        end
      end
      step();
    end
    load_valid = 1'b0;
    if (gaps) begin
      n_cmp++;
      if ((bad != 0) || (n_gaps == 0)) begin
        n_err++;
        $display("FAIL %s_gap_ignore: got %0d nonzero reads over %0d gaps required 0 over >0",
                 tag, bad, n_gaps);
      end
    end
  endtask

  task automatic test_serve_read(input string tag, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] exp);
    gray_req  = 1'b1;
    gray_addr = addr;
    #1;
    n_cmp++;
    if (gray_data !== exp) begin
      n_err++;
      $display("FAIL %s: addr %h got %h required %h", tag, addr, gray_data, exp);
    end
    gray_req = 1'b0;
  endtask

  task automatic test_rd(input string tag, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] exp);
    rd_addr = addr;
    step();
    n_cmp++;
    if (rd_data !== exp) begin
      n_err++;
      $display("FAIL %s: rd_addr %h got %h required %h", tag, addr, rd_data, exp);
    end
  endtask

  task automatic test_serve_flags(input string tag);
    n_cmp++;
    if ({load_ready, gray_ready, done} !== 3'b010) begin
      n_err++;
      $display("FAIL %s: got lr/gr/done=%b required 010", tag, {load_ready, gray_ready, done});
    end
  endtask

  // Run A: load with gaps, stray load beat in SERVE, double write to one address, finish.
  task automatic test_write_finish();
    load_valid = 1'b1;
    load_data  = 8'hEE;
    step();
    load_valid = 1'b0;
    test_serve_read("stray_load_ignored", 14'h0000, 8'h00);
    test_serve_read("serve_read_0081", 14'h0081, 8'h81);
    test_serve_read("serve_read_3fff", 14'h3FFF, 8'hFF);
    gray_req  = 1'b0;
    gray_addr = 14'h0081;
    #1;
    n_cmp++;
    if (gray_data !== 8'h00) begin
      n_err++;
      $display("FAIL serve_no_req: got %h required 00", gray_data);
    end
    lbp_valid = 1'b1;
    lbp_addr  = 14'h0081;
    lbp_data  = 8'h11;
    step();
    lbp_data  = 8'hA5;
    step();
    lbp_valid = 1'b0;
    rd_addr   = 14'h0081;
    step();
    n_cmp++;
    if ((rd_data !== 8'h00) || (done !== 1'b0)) begin
      n_err++;
      $display("FAIL pre_done_rd: got rd=%h done=%b required 00/0", rd_data, done);
    end
    finish = 1'b1;
    step();
    finish = 1'b0;
    n_cmp++;
    if ({gray_ready, done} !== 2'b01) begin
      n_err++;
      $display("FAIL finish_done: got gr/done=%b required 01", {gray_ready, done});
    end
    n_cmp++;
    if (wr_cnt !== 14'd2) begin
      n_err++;
      $display("FAIL wr_cnt_double: got %0d required 2", wr_cnt);
    end
    test_serve_read("done_gray_zero", 14'h0081, 8'h00);
    test_rd("rd_last_write_wins", 14'h0081, 8'hA5);
    test_rd("rd_unwritten_zero", 14'h0000, 8'h00);
    test_rd("rd_load_write_ignored", 14'h0100, 8'h00);
    lbp_valid = 1'b1;
    lbp_addr  = 14'h0000;
    lbp_data  = 8'h77;
    step();
    step();
    lbp_valid = 1'b0;
    test_rd("rd_done_write_ignored", 14'h0000, 8'h00);
    n_cmp++;
    if ((wr_cnt !== 14'd2) || (done !== 1'b1)) begin
      n_err++;
      $display("FAIL done_sticky: got wr_cnt=%0d done=%b required 2/1", wr_cnt, done);
    end
  endtask

  // Run B: abort mid-load, full reload of an inverted image, write+finish in one cycle.
  task automatic test_abort_reload();
    test_reset("reset_from_done");
    test_clear("clear2");
    test_load("partial", 5000, 8'h00, 1'b0);
    n_cmp++;
    if ({load_ready, gray_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL partial_flags: got lr/gr=%b required 10", {load_ready, gray_ready});
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_cmp++;
    if (load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_load_ready: got %b required 0", load_ready);
    end
    test_clear("clear3");
    test_load("reload", N_PIX, 8'hFF, 1'b0);
    test_serve_flags("reload_serve");
    test_serve_read("reload_0000", 14'h0000, 8'hFF);
    test_serve_read("reload_1387", 14'h1387, 8'h78);
    test_serve_read("reload_0081", 14'h0081, 8'h7E);
    lbp_valid = 1'b1;
    lbp_addr  = 14'h3F7E;
    lbp_data  = 8'h3C;
    finish    = 1'b1;
    step();
    lbp_valid = 1'b0;
    finish    = 1'b0;
    n_cmp++;
    if ((done !== 1'b1) || (wr_cnt !== 14'd1)) begin
      n_err++;
      $display("FAIL same_cycle_finish: got done=%b wr_cnt=%0d required 1/1", done, wr_cnt);
    end
    test_rd("rd_same_cycle", 14'h3F7E, 8'h3C);
    test_rd("rd_prior_run_cleared", 14'h0081, 8'h00);
  endtask

  initial begin
    test_reset("reset");
    test_clear("clear1");
    test_load("load", N_PIX, 8'h00, 1'b1);
    test_serve_flags("load_serve");
    test_write_finish();
    test_abort_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run still active at %0t, required completion earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
